mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the MIPS computer. It replaces the fixed PC register, incrementer, branch/jump/JR muxes and clock-divider pacing with a handshaked fetch state machine. It drives instruction memory through a request/response interface, holds one fetched instruction for decode with valid/ready backpressure, and computes redirect targets for branch, jump and JR itself. In-flight wrong-path fetches are discarded.

---
 rtl/mips_fetch_pkg.sv | 21 ++
 rtl/mips_redirect_target.sv | 40 ++++
 rtl/mips_fetch_unit.sv | 136 +++++++++++++
 tb/tb_mips_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg
// Shared types and constants for the MIPS instruction-fetch front end:
//   fetch_state_e : fetch FSM states (REQ, WAIT, DROP)
//   RK_*          : redirect kind encodings driven by execute on redir_kind
//   NOP           : instruction value presented to decode after reset
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [1:0] RK_SEQ    = 2'b00;
  localparam logic [1:0] RK_BRANCH = 2'b01;
  localparam logic [1:0] RK_JUMP   = 2'b10;
  localparam logic [1:0] RK_JR     = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_redirect_target.sv
// mips_redirect_target
// Combinational redirect target computation, shared with the execute stage.
// Ports:
//   kind   in  2       RK_SEQ / RK_BRANCH / RK_JUMP / RK_JR
//   pc2    in  DATA_W  pc2 of the redirecting instruction
//   imm    in  DATA_W  branch offset, jump index in [25:0], or register value
//   target out DATA_W  next fetch address (wraps modulo 2^DATA_W)
module mips_redirect_target
  import mips_fetch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit BYTE_ADDR = 1'b0
) (
  input  logic [1:0]        kind,
  input  logic [DATA_W-1:0] pc2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] target
);

  localparam int SH = BYTE_ADDR ? 2 : 0;
  // Bits of pc2 replaced by the jump index (and its byte shift); the rest
  // are the region bits kept from pc2.
  localparam logic [DATA_W-1:0] JMASK = (DATA_W'(1) << (26 + SH)) - DATA_W'(1);

  logic [DATA_W-1:0] jump_idx;

  assign jump_idx = DATA_W'(imm[25:0]) << SH;

  always_comb begin
    target = pc2;
    unique case (kind)
      RK_SEQ:    target = pc2;
      RK_BRANCH: target = pc2 + (imm << SH);
      RK_JUMP:   target = (pc2 & ~JMASK) | jump_idx;
      RK_JR:     target = imm;
      default:   target = pc2;
    endcase
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit
// Handshaked instruction-fetch front end: issues one fetch at a time to
// instruction memory, holds one instruction for decode with valid/ready
// backpressure, and applies branch/jump/JR/refetch redirects from execute,
// discarding any wrong-path response still in flight.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready, imem_addr  fetch request channel
//   imem_rsp_valid, imem_rsp_data    fetch response (one per accepted request)
//   dec_valid/ready, dec_instr,
//   dec_pc, dec_pc2                  instruction slot towards decode
//   redir_valid/kind/pc2/imm         redirect from execute (highest priority)
//   fetch_count, drop_count          saturating delivered/discarded counters
//
// state | meaning
// REQ   | PC ready to issue; request raised when the decode slot frees up
// WAIT  | request accepted, response will be delivered to decode
// DROP  | request accepted on a dead path, response will be discarded
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter bit                BYTE_ADDR = 1'b0,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [DATA_W-1:0] dec_pc,
  output logic [DATA_W-1:0] dec_pc2,
  input  logic              redir_valid,
  input  logic [1:0]        redir_kind,
  input  logic [DATA_W-1:0] redir_pc2,
  input  logic [DATA_W-1:0] redir_imm,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam logic [DATA_W-1:0] STEP = BYTE_ADDR ? DATA_W'(4) : DATA_W'(1);

  fetch_state_e      state;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] req_pc_q;
  logic [DATA_W-1:0] redir_target;
  logic              slot_free;
  logic              req_fire;

  mips_redirect_target #(
    .DATA_W   (DATA_W),
    .BYTE_ADDR(BYTE_ADDR)
  ) u_target (
    .kind  (redir_kind),
    .pc2   (redir_pc2),
    .imm   (redir_imm),
    .target(redir_target)
  );

  // Only fetch when the instruction we would return has somewhere to land.
  assign slot_free      = !dec_valid || dec_ready;
  assign imem_req_valid = !rst && (state == REQ) && slot_free;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      dec_valid   <= 1'b0;
      dec_instr   <= NOP;
      dec_pc      <= '0;
      dec_pc2     <= '0;
      fetch_count <= '0;
      drop_count  <= '0;
    end else begin
      if (dec_valid && dec_ready)
        dec_valid <= 1'b0;

      if (redir_valid) begin
        pc_q      <= redir_target;
        dec_valid <= 1'b0;
        unique case (state)
          REQ: if (req_fire) state <= DROP;
          // A response in the redirect cycle belongs to the old path; once
          // it is gone nothing is outstanding, so fetch can restart at once.
          // Without one, the in-flight fetch still has to be absorbed.
          WAIT, DROP: begin
            if (imem_rsp_valid) begin
              if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
              state <= REQ;
            end else begin
              state <= DROP;
            end
          end
          default: state <= REQ;
        endcase
      end else begin
        unique case (state)
          REQ: begin
            if (req_fire) begin
              req_pc_q <= pc_q;
              pc_q     <= pc_q + STEP;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rsp_valid) begin
              dec_valid <= 1'b1;
              dec_instr <= imem_rsp_data;
              dec_pc    <= req_pc_q;
              dec_pc2   <= req_pc_q + STEP;
              if (fetch_count != '1) fetch_count <= fetch_count + CNT_W'(1);
              state <= REQ;
            end
          end
          DROP: begin
            if (imem_rsp_valid) begin
              if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
              state <= REQ;
            end
          end
          default: state <= REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit (word-addressed, RESET_PC = 0).
// A memory model answers each accepted fetch after a programmable latency;
// a monitor in the same process compares every issued address and every
// instruction handed to decode against queues filled by the stimulus.
module tb_mips_fetch_unit;
  import mips_fetch_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc2;
    logic [31:0] instr;
  } dec_exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc2;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_pc2;
  logic [31:0] redir_imm;
  logic [15:0] fetch_count;
  logic [15:0] drop_count;

  logic [1:0]  bt_kind;
  logic [31:0] bt_pc2;
  logic [31:0] bt_imm;
  logic [31:0] bt_target;

  int          errors = 0;
  int          checks = 0;
  int          acc_count = 0;
  int          mem_lat = 0;
  bit          inject_stray = 0;
  time         acc_time [0:63];
  logic [31:0] exp_addr_q [$];
  dec_exp_t    exp_dec_q [$];

  mips_fetch_unit #(
    .DATA_W(32), .BYTE_ADDR(1'b0), .RESET_PC(32'h0), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pc2(dec_pc2),
    .redir_valid(redir_valid), .redir_kind(redir_kind),
    .redir_pc2(redir_pc2), .redir_imm(redir_imm),
    .fetch_count(fetch_count), .drop_count(drop_count)
  );

  // Byte-addressed target logic, exercised on its own.
  mips_redirect_target #(.DATA_W(32), .BYTE_ADDR(1'b1)) u_bt (
    .kind(bt_kind), .pc2(bt_pc2), .imm(bt_imm), .target(bt_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h2400_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model + monitor. Response driven at the negedge after acceptance;
  // handshakes sampled 2 ns after each negedge, once inputs have settled.
  logic [31:0] paddr;
  bit          pend = 0;
  int          cnt = 0;
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (inject_stray) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end else if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(paddr);
          pend = 0;
        end else begin
          cnt--;
        end
      end
      #2;
      if (rst) pend = 0;
      if (imem_req_valid && imem_req_ready) begin
        acc_count++;
        if (acc_count < 64) acc_time[acc_count] = $time;
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request: got addr %h expected none", imem_addr);
        end else begin
          chk("issue_addr", imem_addr, exp_addr_q.pop_front());
        end
        pend  = 1;
        paddr = imem_addr;
        cnt   = mem_lat;
      end
      if (dec_valid && dec_ready) begin
        if (exp_dec_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_delivery: got pc %h expected none", dec_pc);
        end else begin
          dec_exp_t e;
          e = exp_dec_q.pop_front();
          chk("deliver_pc", dec_pc, e.pc);
          chk("deliver_pc2", dec_pc2, e.pc2);
          chk("deliver_instr", dec_instr, e.instr);
        end
      end
    end
  end

  // Call right at a negedge; returns 3 ns after the negedge whose sampled
  // handshake brings acc_count to target (acceptance at the next posedge).
  task automatic wait_acc(input int target);
    int n;
    n = 0;
    #3;
    while (acc_count < target && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (acc_count < target) begin
      checks++; errors++;
      $display("FAIL wait_accept: got %0d accepts expected %0d", acc_count, target);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    chk("rst_dec_instr", dec_instr, NOP);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_pc2", dec_pc2, 32'h0);
    chk("rst_fetch_count", {16'h0, fetch_count}, 32'h0);
    chk("rst_drop_count", {16'h0, drop_count}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1;
    redir_valid = 1'b0; redir_kind = RK_SEQ; redir_pc2 = 32'h0; redir_imm = 32'h0;

    // Byte-addressed target computation.
    bt_kind = RK_JUMP; bt_pc2 = 32'h1000_0010; bt_imm = 32'h0000_0008;
    #1 chk("byte_jump_target", bt_target, 32'h1000_0020);
    bt_kind = RK_BRANCH; bt_pc2 = 32'h0000_0100; bt_imm = 32'hFFFF_FFFF;
    #1 chk("byte_branch_target", bt_target, 32'h0000_00FC);

    // Reset and sequential stream 0,1,2,3.
    repeat (3) @(negedge clk);
    #2 check_reset_vals();
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(i);
    for (int i = 0; i < 3; i++) exp_dec_q.push_back('{pc: i, pc2: i + 1, instr: instr_of(i)});
    @(negedge clk);
    rst = 1'b0;
    wait_acc(3);
    chk("issue_spacing_1", 32'(acc_time[2] - acc_time[1]), 32'd20);
    chk("issue_spacing_2", 32'(acc_time[3] - acc_time[2]), 32'd20);

    // Backpressure with pc 2 held.
    @(negedge clk);
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      chk("hold_valid", {31'b0, dec_valid}, 32'h1);
      chk("hold_pc", dec_pc, 32'h2);
      chk("hold_instr", dec_instr, instr_of(2));
      chk("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
      chk("hold_fetch_count", {16'h0, fetch_count}, 32'd3);
    end
    exp_dec_q.push_back('{pc: 3, pc2: 4, instr: instr_of(3)});
    exp_addr_q.push_back(32'h4);
    @(negedge clk);
    dec_ready = 1'b1;
    wait_acc(4);
    mem_lat = 2;
    wait_acc(5);

    // Branch while waiting on a slow response: 5 + (-3) = 2.
    exp_addr_q.push_back(32'h2);
    exp_dec_q.push_back('{pc: 2, pc2: 3, instr: instr_of(2)});
    @(negedge clk);
    redir_valid = 1'b1; redir_kind = RK_BRANCH;
    redir_pc2 = 32'h5; redir_imm = 32'hFFFF_FFFD;
    mem_lat = 0;
    @(negedge clk);
    redir_valid = 1'b0;
    wait_acc(6);
    chk("branch_drop_count", {16'h0, drop_count}, 32'd1);

    // Jump in REQ with memory stalled.
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    redir_valid = 1'b1; redir_kind = RK_JUMP;
    redir_pc2 = 32'h0400_0010; redir_imm = 32'h0000_0020;
    exp_addr_q.push_back(32'h0400_0020);
    @(negedge clk);
    redir_valid = 1'b0;
    imem_req_ready = 1'b1;
    wait_acc(7);

    // JR arriving together with the response.
    @(negedge clk);
    redir_valid = 1'b1; redir_kind = RK_JR;
    redir_pc2 = 32'h0400_0021; redir_imm = 32'h0000_001C;
    exp_addr_q.push_back(32'h0000_001C);
    @(negedge clk);
    redir_valid = 1'b0;
    #3;
    chk("jr_dec_valid", {31'b0, dec_valid}, 32'h0);
    chk("jr_drop_count", {16'h0, drop_count}, 32'd2);
    chk("jr_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("jr_addr", imem_addr, 32'h0000_001C);
    @(negedge clk);
    dec_ready = 1'b0;
    @(negedge clk);
    #3;
    chk("jr_loaded_pc", dec_pc, 32'h1C);
    chk("jr_loaded_pc2", dec_pc2, 32'h1D);
    chk("jr_loaded_instr", dec_instr, instr_of(32'h1C));
    chk("jr_fetch_count", {16'h0, fetch_count}, 32'd6);
    chk("jr_stalled", {31'b0, imem_req_valid}, 32'h0);

    // Reset while a slow fetch is outstanding, then a stray response.
    exp_dec_q.push_back('{pc: 32'h1C, pc2: 32'h1D, instr: instr_of(32'h1C)});
    exp_addr_q.push_back(32'h1D);
    mem_lat = 3;
    @(negedge clk);
    dec_ready = 1'b1;
    wait_acc(9);
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 1'b0;
    @(negedge clk);
    #3 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    #4 inject_stray = 1'b1;
    @(negedge clk);
    #3 inject_stray = 1'b0;
    @(negedge clk);
    #3;
    chk("stray_dec_valid", {31'b0, dec_valid}, 32'h0);
    chk("stray_fetch_count", {16'h0, fetch_count}, 32'd0);
    chk("stray_drop_count", {16'h0, drop_count}, 32'd0);
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    exp_addr_q.push_back(32'h0);
    exp_dec_q.push_back('{pc: 0, pc2: 1, instr: instr_of(0)});
    mem_lat = 0;
    @(negedge clk);
    imem_req_ready = 1'b1;
    wait_acc(10);
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && exp_dec_q.size() != 0; i++) begin
      @(negedge clk);
      #3;
    end
    chk("dec_queue_drained", 32'(exp_dec_q.size()), 32'd0);
    chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
